// File: rtl/display_pkg.sv
// Shared definitions for the debug display sequencer: select codes, FSM states,
// default select width.
package display_pkg;

    localparam int SEL_W_DEF = 11;

    // Datapath register codes presented on the debug display mux.
    typedef enum int unsigned {
        SEL_PC = 10,
        SEL_IR = 11,
        SEL_RA = 12,
        SEL_RB = 13,
        SEL_RZ = 14,
        SEL_RM = 15,
        SEL_RY = 16
    } sel_code_t;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/btn_edge_sync.sv
// Three-flop synchroniser for an asynchronous board key plus a rising-edge
// detector on the synchronised level.
module btn_edge_sync (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s1 may be metastable; only s2/s3 feed logic.
    assign rise = s2 & ~s3;

endmodule

// File: rtl/display_scan_ctrl.sv
// Debug display sequencer: steps the mux select through the register ring by
// dwell timer, step key or direct jump, blanking the display after each change.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SEL_W        = SEL_W_DEF,
    parameter int SEL_FIRST    = int'(SEL_PC),
    parameter int SEL_LAST     = int'(SEL_RY),
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode_auto,
    input  logic             hold,
    input  logic             step_btn,
    input  logic             jump_valid,
    input  logic [SEL_W-1:0] jump_sel,
    output logic [SEL_W-1:0] select,
    output logic             disp_enable_n,
    output logic             wrap_pulse,
    output logic             jump_err
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [SEL_W-1:0] FIRST      = SEL_W'(SEL_FIRST);
    localparam logic [SEL_W-1:0] LAST       = SEL_W'(SEL_LAST);
    localparam logic [DW-1:0]    DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0]    BLANK_LAST = BW'(BLANK_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_d;
    logic [BW-1:0]    blank_q, blank_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic             pend_q, pend_d;
    logic             wrap_d, jerr_d;
    logic             step_rise;
    logic             jump_ok, advance;

    btn_edge_sync u_step_sync (
        .clock (clock),
        .reset (reset),
        .btn   (step_btn),
        .rise  (step_rise)
    );

    assign jump_ok = jump_valid && (jump_sel >= FIRST) && (jump_sel <= LAST);

    // Hold gates every advance source, including an already queued step.
    assign advance = (state_q == ST_SHOW) && !hold &&
                     (step_rise || pend_q || (mode_auto && dwell_q == DWELL_LAST));

    always_comb begin
        state_d = state_q;
        sel_d   = select;
        blank_d = blank_q;
        dwell_d = dwell_q;
        pend_d  = pend_q;
        wrap_d  = 1'b0;
        jerr_d  = jump_valid && !jump_ok;

        if (jump_ok) begin
            sel_d   = jump_sel;
            state_d = ST_BLANK;
            blank_d = '0;
            dwell_d = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    dwell_d = '0;
                    if (step_rise && !hold)
                        pend_d = 1'b1;
                    if (blank_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        blank_d = '0;
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                ST_SHOW: begin
                    if (advance) begin
                        wrap_d  = (select == LAST);
                        sel_d   = (select == LAST) ? FIRST : select + SEL_W'(1);
                        state_d = ST_BLANK;
                        blank_d = '0;
                        dwell_d = '0;
                        pend_d  = 1'b0;
                    end else if (mode_auto && !hold) begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            select        <= FIRST;
            blank_q       <= '0;
            dwell_q       <= '0;
            pend_q        <= 1'b0;
            disp_enable_n <= 1'b1;
            wrap_pulse    <= 1'b0;
            jump_err      <= 1'b0;
        end else begin
            state_q       <= state_d;
            select        <= sel_d;
            blank_q       <= blank_d;
            dwell_q       <= dwell_d;
            pend_q        <= pend_d;
            disp_enable_n <= (state_d == ST_BLANK);
            wrap_pulse    <= wrap_d;
            jump_err      <= jerr_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed and randomized checks of display_scan_ctrl against a cycle-level
// behavioural model (blank countdown, dwell count, delayed key samples).
module tb_display_scan_ctrl;

    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int FIRST = 10;
    localparam int LAST  = 16;

    logic        clock = 1'b0;
    logic        reset, mode_auto, hold, step_btn, jump_valid;
    logic [10:0] jump_sel;
    logic [10:0] select;
    logic        disp_enable_n, wrap_pulse, jump_err;

    int total = 0;
    int bad   = 0;

    // model state
    int m_sel, m_bl, m_dw;
    bit m_pend, m_wrap, m_jerr;
    bit h0, h1, h2;

    display_scan_ctrl #(
        .SEL_W(11), .SEL_FIRST(FIRST), .SEL_LAST(LAST),
        .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
    ) dut (
        .clock(clock), .reset(reset), .mode_auto(mode_auto), .hold(hold),
        .step_btn(step_btn), .jump_valid(jump_valid), .jump_sel(jump_sel),
        .select(select), .disp_enable_n(disp_enable_n),
        .wrap_pulse(wrap_pulse), .jump_err(jump_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs now applied.
    task automatic model_step();
        bit rise, in_range;
        if (reset) begin
            m_sel = FIRST; m_bl = BLANK; m_dw = 0; m_pend = 0;
            m_wrap = 0; m_jerr = 0; h0 = 0; h1 = 0; h2 = 0;
            return;
        end
        rise = h1 && !h2;
        h2 = h1; h1 = h0; h0 = step_btn;
        in_range = (int'(jump_sel) >= FIRST) && (int'(jump_sel) <= LAST);
        m_wrap = 0;
        m_jerr = jump_valid && !in_range;
        if (jump_valid && in_range) begin
            m_sel = int'(jump_sel); m_bl = BLANK; m_dw = 0; m_pend = 0;
        end else if (m_bl != 0) begin
            if (rise && !hold) m_pend = 1;
            m_bl--;
            m_dw = 0;
        end else if (!hold && (rise || m_pend || (mode_auto && m_dw == DWELL - 1))) begin
            m_wrap = (m_sel == LAST);
            m_sel  = m_wrap ? FIRST : m_sel + 1;
            m_bl = BLANK; m_dw = 0; m_pend = 0;
        end else if (mode_auto && !hold) begin
            m_dw++;
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clock);
        #1;
        chk({tag, ".sel"},  32'(select),        32'(m_sel));
        chk({tag, ".dis"},  32'(disp_enable_n), 32'(m_bl != 0));
        chk({tag, ".wrap"}, 32'(wrap_pulse),    32'(m_wrap));
        chk({tag, ".jerr"}, 32'(jump_err),      32'(m_jerr));
    endtask

    task automatic jump_to(input int code);
        jump_valid = 1'b1; jump_sel = 11'(code);
        cycle("jmp");
        jump_valid = 1'b0;
        cycle("jmp_b1");
        cycle("jmp_b2");
    endtask

    initial begin
        int wraps, d0, n;
        bit changed;
        reset = 1'b1; mode_auto = 1'b0; hold = 1'b0; step_btn = 1'b0;
        jump_valid = 1'b0; jump_sel = '0;

        // reset state
        cycle("rst0");
        cycle("rst1");
        chk("rst_sel", 32'(select), 32'd10);
        chk("rst_dis", 32'(disp_enable_n), 32'd1);

        // auto scan through the full ring
        reset = 1'b0; mode_auto = 1'b1; wraps = 0;
        for (int i = 1; i <= 70; i++) begin
            cycle("ring");
            wraps += int'(wrap_pulse);
            if (i == 1)  chk("ring_blank1", 32'(disp_enable_n), 32'd1);
            if (i == 2)  chk("ring_show",   32'(disp_enable_n), 32'd0);
            if (i == 9)  chk("ring_dwell",  32'(select), 32'd10);
            if (i == 10) chk("ring_next",   32'(select), 32'd11);
            if (i == 60) chk("ring_ry",     32'(select), 32'd16);
            if (i == 70) chk("ring_wrap",   32'(wrap_pulse), 32'd1);
        end
        chk("ring_wraps", 32'(wraps), 32'd1);
        chk("ring_back", 32'(select), 32'd10);

        // manual step with key held for 5 cycles
        mode_auto = 1'b0;
        jump_to(12);
        step_btn = 1'b1;
        cycle("stp_k");
        cycle("stp_k1");
        chk("stp_early", 32'(select), 32'd12);
        cycle("stp_k2");
        chk("stp_adv", 32'(select), 32'd13);
        cycle("stp_k3");
        cycle("stp_k4");
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) cycle("stp_idle");
        chk("stp_once", 32'(select), 32'd13);

        // valid and out-of-range jumps
        jump_to(11);
        jump_valid = 1'b1; jump_sel = 11'd15;
        cycle("jv");
        jump_valid = 1'b0;
        chk("jv_sel", 32'(select), 32'd15);
        chk("jv_dis", 32'(disp_enable_n), 32'd1);
        cycle("jv_b1");
        chk("jv_b1_dis", 32'(disp_enable_n), 32'd1);
        cycle("jv_b2");
        chk("jv_show", 32'(disp_enable_n), 32'd0);
        jump_to(11);
        jump_valid = 1'b1; jump_sel = 11'd3;
        cycle("jerr");
        jump_valid = 1'b0;
        chk("jerr_pulse", 32'(jump_err), 32'd1);
        chk("jerr_sel", 32'(select), 32'd11);
        chk("jerr_dis", 32'(disp_enable_n), 32'd0);
        cycle("jerr_after");
        chk("jerr_clear", 32'(jump_err), 32'd0);

        // dwell expiry, step edge and jump on the same edge
        mode_auto = 1'b1;
        n = 0;
        while (!(m_bl == 0 && m_dw == DWELL - 3) && n < 40) begin
            cycle("cf_wait");
            n++;
        end
        if (n >= 40) begin
            total++; bad++;
            $error("FAIL cf_wait_timeout observed=%0d expected=%0d", m_dw, DWELL - 3);
        end
        step_btn = 1'b1;
        cycle("cf_k");
        step_btn = 1'b0;
        cycle("cf_k1");
        jump_valid = 1'b1; jump_sel = 11'd14;
        cycle("cf_hit");
        jump_valid = 1'b0; mode_auto = 1'b0;
        chk("cf_sel", 32'(select), 32'd14);
        chk("cf_wrap", 32'(wrap_pulse), 32'd0);
        for (int i = 0; i < 6; i++) cycle("cf_idle");
        chk("cf_no_pend", 32'(select), 32'd14);

        // step edge queued during the blank after 13->14
        jump_to(13);
        cycle("q_show");
        step_btn = 1'b1; cycle("q_k");
        step_btn = 1'b0; cycle("q_k1");
        step_btn = 1'b1; cycle("q_k2");
        chk("q_adv14", 32'(select), 32'd14);
        step_btn = 1'b0; cycle("q_k3");
        cycle("q_k4");
        chk("q_still14", 32'(select), 32'd14);
        chk("q_show14", 32'(disp_enable_n), 32'd0);
        cycle("q_k5");
        chk("q_adv15", 32'(select), 32'd15);
        for (int i = 0; i < 4; i++) cycle("q_idle");

        // hold in auto mode
        mode_auto = 1'b1;
        for (int i = 0; i < 3; i++) cycle("h_pre");
        d0 = m_dw;
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step_btn = (i % 4 < 2) && (i < 14);
            cycle("h_frz");
            chk("h_const", 32'(select), 32'd15);
        end
        step_btn = 1'b0;
        hold = 1'b0;
        n = 0; changed = 0;
        while (!changed && n < 2 * DWELL) begin
            cycle("h_rel");
            n++;
            changed = (select != 11'd15);
        end
        chk("h_resume", 32'(n), 32'(DWELL - d0));
        hold = 1'b1;
        for (int i = 0; i < 4; i++) cycle("h_pre2");
        jump_valid = 1'b1; jump_sel = 11'd10;
        cycle("h_jump");
        jump_valid = 1'b0;
        chk("h_jump_sel", 32'(select), 32'd10);
        hold = 1'b0; mode_auto = 1'b0;
        for (int i = 0; i < 3; i++) cycle("h_post");

        // reset during a blank with a queued step
        step_btn = 1'b1; cycle("r_k");
        step_btn = 1'b0; jump_valid = 1'b1; jump_sel = 11'd14;
        cycle("r_jump");
        jump_valid = 1'b0;
        cycle("r_pend");
        chk("r_blank14", 32'(select), 32'd14);
        reset = 1'b1;
        cycle("r_rst");
        chk("r_sel", 32'(select), 32'd10);
        chk("r_dis", 32'(disp_enable_n), 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle("r_after");
        chk("r_no_pend", 32'(select), 32'd10);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) mode_auto = ~mode_auto;
            hold       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
            jump_valid = ($urandom_range(0, 11) == 0);
            jump_sel   = 11'($urandom_range(0, 20));
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
